// File: rtl/llki_pkg.sv
// Shared definitions for the LLKI discrete key-load channel: message ids,
// completion codes, command opcodes and master FSM states.
package llki_pkg;

    localparam logic [7:0] MID_KEY_LOAD   = 8'h02;
    localparam logic [7:0] MID_KEY_CLEAR  = 8'h03;
    localparam logic [7:0] MID_KEY_STATUS = 8'h04;
    localparam logic [7:0] MID_RESP_BIT   = 8'h80;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_TIMEOUT  = 8'hE0;
    localparam logic [7:0] ST_BAD_RESP = 8'hE1;
    localparam logic [7:0] ST_BAD_CMD  = 8'hE2;

    typedef enum logic [1:0] {
        OP_KEY_LOAD   = 2'd0,
        OP_KEY_CLEAR  = 2'd1,
        OP_KEY_STATUS = 2'd2,
        OP_ILLEGAL    = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_RDWAIT    = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_RESP = 3'd4,
        S_DONE      = 3'd5
    } state_e;

    // Request message id carried for each legal opcode.
    function automatic logic [7:0] op_msg_id(input cmd_op_e op);
        logic [7:0] id;
        case (op)
            OP_KEY_LOAD:  id = MID_KEY_LOAD;
            OP_KEY_CLEAR: id = MID_KEY_CLEAR;
            default:      id = MID_KEY_STATUS;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/llki_timeout_ctr.sv
// Per-message watchdog: counts enabled cycles after a clear and flags
// expiry once TIMEOUT_CYCLES-1 is reached. It saturates until cleared.
module llki_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // Cycle counter, restarted at the start of every message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/llki_discrete_master.sv
// Initiator end of the LLKI discrete key-load channel. Runs one command at a
// time, streams key words from the local key RAM as request messages, checks
// each slave response and reports one completion status per command.
module llki_discrete_master
    import llki_pkg::*;
#(
    parameter int KEY_WORDS_MAX  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [3:0]                       cmd_num_words,
    output logic                             keymem_rd_en,
    output logic [$clog2(KEY_WORDS_MAX)-1:0] keymem_rd_addr,
    input  logic [63:0]                      keymem_rd_data,
    output logic                             busy,
    output logic                             done_valid,
    output logic [7:0]                       done_status,
    output logic                             llki_req_valid,
    input  logic                             llki_req_ready,
    output logic [7:0]                       llki_req_msg_id,
    output logic [63:0]                      llki_req_data,
    input  logic                             llki_resp_valid,
    output logic                             llki_resp_ready,
    input  logic [7:0]                       llki_resp_msg_id,
    input  logic [7:0]                       llki_resp_status
);
    localparam int ADDR_W = $clog2(KEY_WORDS_MAX);

    state_e            state, state_nx;
    cmd_op_e           op;
    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        num_words_q;
    logic              is_load_q;
    logic [7:0]        msg_id_q;
    logic [63:0]       req_data_q;
    logic [7:0]        done_status_q;

    logic              cmd_start, data_ld, idx_inc, fin;
    logic [7:0]        fin_code;
    logic              tmo_clr, tmo_en, tmo_expired;
    logic              num_ok, last_word, resp_id_ok;

    assign op         = cmd_op_e'(cmd_op);
    assign num_ok     = (cmd_num_words != 4'd0) && (int'(cmd_num_words) <= KEY_WORDS_MAX);
    assign last_word  = (int'(word_idx) + 1) >= int'(num_words_q);
    assign resp_id_ok = (llki_resp_msg_id == (msg_id_q | MID_RESP_BIT));

    llki_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmo_clr),
        .enable (tmo_en),
        .expired(tmo_expired)
    );

    // FSM state register; reset aborts any command without a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode, handshake outputs and datapath strobes.
    always_comb begin
        state_nx        = state;
        cmd_ready       = 1'b0;
        busy            = 1'b1;
        keymem_rd_en    = 1'b0;
        llki_req_valid  = 1'b0;
        llki_resp_ready = 1'b0;
        done_valid      = 1'b0;
        cmd_start       = 1'b0;
        data_ld         = 1'b0;
        idx_inc         = 1'b0;
        fin             = 1'b0;
        fin_code        = ST_OK;
        tmo_clr         = 1'b0;
        tmo_en          = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready       = 1'b1;
                busy            = 1'b0;
                // Responses arriving here are stray; accept and discard them.
                llki_resp_ready = 1'b1;
                if (cmd_valid) begin
                    case (op)
                        OP_KEY_LOAD: begin
                            if (num_ok) begin
                                cmd_start = 1'b1;
                                state_nx  = S_FETCH;
                            end else begin
                                fin      = 1'b1;
                                fin_code = ST_BAD_CMD;
                                state_nx = S_DONE;
                            end
                        end
                        OP_KEY_CLEAR, OP_KEY_STATUS: begin
                            cmd_start = 1'b1;
                            tmo_clr   = 1'b1;
                            state_nx  = S_SEND;
                        end
                        default: begin
                            fin      = 1'b1;
                            fin_code = ST_BAD_CMD;
                            state_nx = S_DONE;
                        end
                    endcase
                end
            end
            S_FETCH: begin
                keymem_rd_en = 1'b1;
                state_nx     = S_RDWAIT;
            end
            S_RDWAIT: begin
                data_ld  = 1'b1;
                tmo_clr  = 1'b1;
                state_nx = S_SEND;
            end
            S_SEND: begin
                llki_req_valid = 1'b1;
                tmo_en         = 1'b1;
                if (llki_req_ready) begin
                    state_nx = S_WAIT_RESP;
                end else if (tmo_expired) begin
                    fin      = 1'b1;
                    fin_code = ST_TIMEOUT;
                    state_nx = S_DONE;
                end
            end
            S_WAIT_RESP: begin
                llki_resp_ready = 1'b1;
                tmo_en          = 1'b1;
                if (llki_resp_valid) begin
                    if (!resp_id_ok) begin
                        fin      = 1'b1;
                        fin_code = ST_BAD_RESP;
                        state_nx = S_DONE;
                    end else if (llki_resp_status != ST_OK) begin
                        fin      = 1'b1;
                        fin_code = llki_resp_status;
                        state_nx = S_DONE;
                    end else if (is_load_q && !last_word) begin
                        idx_inc  = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        fin      = 1'b1;
                        fin_code = ST_OK;
                        state_nx = S_DONE;
                    end
                end else if (tmo_expired) begin
                    fin      = 1'b1;
                    fin_code = ST_TIMEOUT;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                state_nx   = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Command context, request message registers and completion code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load_q     <= 1'b0;
            num_words_q   <= 4'd0;
            word_idx      <= '0;
            msg_id_q      <= 8'h00;
            req_data_q    <= 64'h0;
            done_status_q <= ST_OK;
        end else begin
            if (cmd_start) begin
                is_load_q   <= (op == OP_KEY_LOAD);
                num_words_q <= cmd_num_words;
                word_idx    <= '0;
                msg_id_q    <= op_msg_id(op);
                req_data_q  <= 64'h0;
            end
            if (data_ld) begin
                req_data_q <= keymem_rd_data;
            end
            if (idx_inc) begin
                word_idx <= word_idx + ADDR_W'(1);
            end
            if (fin) begin
                done_status_q <= fin_code;
            end
        end
    end

    assign keymem_rd_addr  = word_idx;
    assign llki_req_msg_id = msg_id_q;
    assign llki_req_data   = req_data_q;
    assign done_status     = done_status_q;

endmodule

// File: tb/tb_llki_discrete_master.sv
// Directed bench for llki_discrete_master with a reactive slave, key RAM model
// and completion monitor.
module tb_llki_discrete_master;
    import llki_pkg::*;

    localparam int KW  = 8;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [3:0]  cmd_num_words = 4'd0;
    logic        keymem_rd_en;
    logic [2:0]  keymem_rd_addr;
    logic [63:0] keymem_rd_data = 64'h0;
    logic        busy, done_valid;
    logic [7:0]  done_status;
    logic        llki_req_valid;
    logic        llki_req_ready = 1'b0;
    logic [7:0]  llki_req_msg_id;
    logic [63:0] llki_req_data;
    logic        llki_resp_valid = 1'b0;
    logic        llki_resp_ready;
    logic [7:0]  llki_resp_msg_id = 8'h00;
    logic [7:0]  llki_resp_status = 8'h00;

    llki_discrete_master #(.KEY_WORDS_MAX(KW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_num_words(cmd_num_words),
        .keymem_rd_en(keymem_rd_en), .keymem_rd_addr(keymem_rd_addr), .keymem_rd_data(keymem_rd_data),
        .busy(busy), .done_valid(done_valid), .done_status(done_status),
        .llki_req_valid(llki_req_valid), .llki_req_ready(llki_req_ready),
        .llki_req_msg_id(llki_req_msg_id), .llki_req_data(llki_req_data),
        .llki_resp_valid(llki_resp_valid), .llki_resp_ready(llki_resp_ready),
        .llki_resp_msg_id(llki_resp_msg_id), .llki_resp_status(llki_resp_status)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // key RAM model: one-cycle read latency
    logic [63:0] ram [KW];
    always @(posedge clk) begin
        if (keymem_rd_en) keymem_rd_data <= ram[keymem_rd_addr];
    end

    // cycle counter
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // slave configuration (written by main only)
    int         stall_tab [8];
    int         req_base = 0;
    int         err_word = -1;
    logic [7:0] err_status = 8'h00;
    int         mute_word = -1;
    bit         silent = 1'b0;
    bit         bad_id = 1'b0;
    bit         spur = 1'b0;

    // slave/monitor state (written by slave only)
    int          nreq = 0, valid_cycles = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, stable_err = 0;
    logic [7:0]  last_status = 8'h00;
    logic [7:0]  req_id_log [$];
    logic [63:0] req_dat_log [$];

    initial begin : slave
        int         stall_left;
        bit         in_req, pend;
        logic [7:0] cur_id, pend_id;
        logic [63:0] cur_data;
        int         pend_word, widx;
        stall_left = 0; in_req = 0; pend = 0; cur_id = 0; pend_id = 0; cur_data = 0; pend_word = 0;
        forever begin
            @(negedge clk);
            llki_req_ready   = 1'b0;
            llki_resp_valid  = 1'b0;
            llki_resp_msg_id = 8'h00;
            llki_resp_status = 8'h00;
            if (llki_req_valid) valid_cycles++;
            if (keymem_rd_en) rd_cnt++;
            if (done_valid) begin
                done_cnt++;
                last_status = done_status;
                done_cyc = cyc;
            end
            if (!rst_n) begin
                in_req = 0;
                pend = 0;
            end else if (spur) begin
                llki_resp_valid  = 1'b1;
                llki_resp_msg_id = 8'h84;
                llki_resp_status = 8'h55;
            end else if (pend) begin
                pend = 0;
                llki_resp_valid  = 1'b1;
                llki_resp_msg_id = bad_id ? pend_id : (pend_id | 8'h80);
                llki_resp_status = (pend_word == err_word) ? err_status : 8'h00;
            end else if (llki_req_valid && !silent) begin
                widx = nreq - req_base;
                if (!in_req) begin
                    in_req = 1;
                    stall_left = stall_tab[widx & 7];
                    cur_id = llki_req_msg_id;
                    cur_data = llki_req_data;
                end else if (llki_req_data !== cur_data || llki_req_msg_id !== cur_id) begin
                    stable_err++;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    llki_req_ready = 1'b1;
                    req_id_log.push_back(llki_req_msg_id);
                    req_dat_log.push_back(llki_req_data);
                    in_req = 0;
                    if (widx != mute_word) begin
                        pend = 1;
                        pend_id = llki_req_msg_id;
                        pend_word = widx;
                    end
                    nreq++;
                end
            end
        end
    end

    int acc_cyc = 0;
    int done_base = 0;

    task automatic issue(input logic [1:0] op, input logic [3:0] nw);
        int g;
        g = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_num_words = nw;
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("cmd_accept", cmd_ready, 1'b1);
        acc_cyc = cyc;
        done_base = done_cnt;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_num_words = 4'd0;
    endtask

    task automatic wait_done(input int budget);
        int g;
        g = 0;
        while (done_cnt == done_base && g < budget) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", done_cnt != done_base, 1'b1);
        @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rd_en"}, keymem_rd_en, 1'b0);
        chk({tag, "_rd_addr"}, keymem_rd_addr, 3'd0);
        chk({tag, "_req_valid"}, llki_req_valid, 1'b0);
        chk({tag, "_req_id"}, llki_req_msg_id, 8'h00);
        chk({tag, "_req_data"}, llki_req_data, 64'h0);
        chk({tag, "_done_valid"}, done_valid, 1'b0);
        chk({tag, "_done_status"}, done_status, 8'h00);
        chk({tag, "_resp_ready"}, llki_resp_ready, 1'b1);
    endtask

    initial begin : main
        int vc0, rd0, st0, d0, g;
        for (int i = 0; i < KW; i++) begin
            ram[i] = {8{8'hA0 + 8'(i)}};
            stall_tab[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs("post_rst");

        // spurious response in IDLE is dropped
        d0 = done_cnt;
        spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("spur_done_cnt", done_cnt, d0);
        chk("spur_status", done_status, 8'h00);
        chk("spur_busy", busy, 1'b0);

        // 1: STATUS best case
        req_base = nreq;
        issue(2'd2, 4'd0);
        wait_done(100);
        chk("t1_lat", done_cyc - acc_cyc, 3);
        chk("t1_status", last_status, 8'h00);
        chk("t1_nreq", nreq - req_base, 1);
        chk("t1_id", req_id_log[req_base], 8'h04);
        chk("t1_data", req_dat_log[req_base], 64'h0);

        // 2: LOAD 4 words with 0..3 ready stalls
        req_base = nreq; rd0 = rd_cnt; st0 = stable_err;
        for (int i = 0; i < 4; i++) stall_tab[i] = i;
        issue(2'd0, 4'd4);
        wait_done(300);
        chk("t2_status", last_status, 8'h00);
        chk("t2_lat", done_cyc - acc_cyc, 23);
        chk("t2_nreq", nreq - req_base, 4);
        chk("t2_rd_cnt", rd_cnt - rd0, 4);
        chk("t2_stable", stable_err - st0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_id", req_id_log[req_base + i], 8'h02);
            chk("t2_data", req_dat_log[req_base + i], {8{8'hA0 + 8'(i)}});
        end
        for (int i = 0; i < 4; i++) stall_tab[i] = 0;

        // 3: LOAD 3 words, slave error on word 1
        req_base = nreq; rd0 = rd_cnt;
        err_word = 1; err_status = 8'h05;
        issue(2'd0, 4'd3);
        wait_done(200);
        chk("t3_status", last_status, 8'h05);
        chk("t3_nreq", nreq - req_base, 2);
        chk("t3_rd_cnt", rd_cnt - rd0, 2);
        chk("t3_lat", done_cyc - acc_cyc, 9);
        err_word = -1;

        // 4: STATUS with silent slave -> timeout
        vc0 = valid_cycles;
        silent = 1'b1;
        issue(2'd2, 4'd0);
        wait_done(TMO + 200);
        chk("t4_status", last_status, 8'hE0);
        chk("t4_valid_cycles", valid_cycles - vc0, TMO);
        chk("t4_lat", done_cyc - acc_cyc, TMO + 1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_cmd_ready", cmd_ready, 1'b1);
        chk("t4_req_valid", llki_req_valid, 1'b0);
        silent = 1'b0;

        // 5: illegal commands -> BAD_CMD, no traffic
        for (int k = 0; k < 3; k++) begin
            vc0 = valid_cycles; rd0 = rd_cnt;
            case (k)
                0: issue(2'd0, 4'd0);
                1: issue(2'd0, 4'd9);
                default: issue(2'd3, 4'd2);
            endcase
            wait_done(50);
            chk("t5_status", last_status, 8'hE2);
            chk("t5_lat", done_cyc - acc_cyc, 1);
            chk("t5_no_req", valid_cycles - vc0, 0);
            chk("t5_no_rd", rd_cnt - rd0, 0);
        end

        // CLEAR with wrong response id -> BAD_RESP, then CLEAR OK
        bad_id = 1'b1;
        issue(2'd1, 4'd0);
        wait_done(100);
        chk("clr_bad_status", last_status, 8'hE1);
        bad_id = 1'b0;
        req_base = nreq;
        issue(2'd1, 4'd0);
        wait_done(100);
        chk("clr_status", last_status, 8'h00);
        chk("clr_id", req_id_log[req_base], 8'h03);
        chk("clr_data", req_dat_log[req_base], 64'h0);

        // 6: reset during WAIT_RESP of LOAD word 2
        req_base = nreq;
        mute_word = 2;
        issue(2'd0, 4'd4);
        g = 0;
        while (nreq - req_base < 3 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("t6_reach_w2", nreq - req_base, 3);
        @(posedge clk);
        #1;
        chk("t6_busy_pre", busy, 1'b1);
        chk("t6_addr_pre", keymem_rd_addr, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs("t6_rst");
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_done", done_cnt, d0);
        chk("t6_idle", busy, 1'b0);
        mute_word = -1;
        req_base = nreq;
        issue(2'd2, 4'd0);
        wait_done(100);
        chk("t6_status", last_status, 8'h00);
        chk("t6_lat", done_cyc - acc_cyc, 3);
        chk("t6_id", req_id_log[req_base], 8'h04);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
